// File: rtl/wash_pkg.sv
// Shared types and constants for the wash sequencer.
// Optional build macro: LAMP_TEST_EN adds a power-on lamp test state.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5
`ifdef LAMP_TEST_EN
        , ST_LAMP = 3'd6
`endif
    } state_t;

    typedef struct packed {
        logic [5:0] level;
        logic [5:0] wash;
        logic [5:0] spin;
    } prog_t;

    localparam logic [5:0] GLYPH_BLANK = 6'd55;
    localparam logic [5:0] GLYPH_LAMP  = 6'd56;
    localparam logic [5:0] GLYPH_END   = 6'd60;

    localparam logic [5:0] FILL_STEP   = 6'd2;
    localparam logic [5:0] DRAIN_STEP  = 6'd4;

    // Display total for mode 0, shown straight out of reset.
    localparam logic [5:0] RESET_TOTAL = 6'd40;

    localparam logic [1:0] LAMP_TICKS  = 2'd3;

    function automatic logic [5:0] prog_total(input prog_t p);
        return p.wash + p.spin;
    endfunction

endpackage

// File: rtl/wash_program_table.sv
// Program lookup: mode -> fill level, wash seconds, spin seconds.
module wash_program_table
    import wash_pkg::*;
(
    input  logic [1:0] mode,
    output prog_t      prog
);

    // Fixed program table, purely combinational.
    always_comb begin
        unique case (mode)
            2'd0:    prog = '{level: 6'd20, wash: 6'd30, spin: 6'd10};
            2'd1:    prog = '{level: 6'd12, wash: 6'd12, spin: 6'd6};
            2'd2:    prog = '{level: 6'd30, wash: 6'd40, spin: 6'd12};
            default: prog = '{level: 6'd16, wash: 6'd8,  spin: 6'd4};
        endcase
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing machine program sequencer with display outputs.
// Optional build macro: LAMP_TEST_EN (reset enters a 3-tick lamp test).
//
// state    | meaning
// IDLE     | waiting for start, shows selected program total
// FILL     | adding water until the program level
// WASH     | counting down wash seconds
// DRAIN    | removing water until empty
// SPIN     | counting down spin seconds
// DONE     | program finished, waits for start acknowledge
// LAMP     | all display fields lit (LAMP_TEST_EN builds only)
module wash_sequencer
    import wash_pkg::*;
(
    input  logic       clk,
    input  logic       uRst_,
    input  logic       uTick,
    input  logic       uStart,
    input  logic       uPause,
    input  logic [1:0] uMode,
    output logic [5:0] yTot,
    output logic [5:0] yCur,
    output logic [5:0] yWat,
    output logic [2:0] yPhase,
    output logic       yDone
);

    state_t     state, state_n;
    logic [5:0] level_q, level_n;
    logic [5:0] wash_cnt, wash_n;
    logic [5:0] spin_cnt, spin_n;
    logic [5:0] wat, wat_n;
    logic       paused, paused_n;
    logic       blink, blink_n;
    logic       running, advance;
    logic [5:0] tot_n, cur_n, wat_o_n;
    logic       done_n;
    prog_t      prog_sel;
`ifdef LAMP_TEST_EN
    logic [1:0] lamp_cnt, lamp_n;
`endif

    wash_program_table u_table (
        .mode (uMode),
        .prog (prog_sel)
    );

    assign yPhase = state;

    // Next-state, counter and display decode.
    always_comb begin
        state_n  = state;
        level_n  = level_q;
        wash_n   = wash_cnt;
        spin_n   = spin_cnt;
        wat_n    = wat;
        paused_n = paused;
        blink_n  = blink;
        advance  = 1'b0;
`ifdef LAMP_TEST_EN
        lamp_n   = lamp_cnt;
`endif
        running  = (state == ST_FILL) || (state == ST_WASH) ||
                   (state == ST_DRAIN) || (state == ST_SPIN);

        // Pause is resolved before the tick: a tick entering pause is
        // dropped, a tick leaving pause still advances.
        if (running && uPause) begin
            paused_n = ~paused;
            blink_n  = 1'b0;
            advance  = uTick & paused;
        end else if (running && uTick) begin
            if (paused) blink_n = ~blink;
            else        advance = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (uStart) begin
                    level_n  = prog_sel.level;
                    wash_n   = prog_sel.wash;
                    spin_n   = prog_sel.spin;
                    wat_n    = 6'd0;
                    paused_n = 1'b0;
                    blink_n  = 1'b0;
                    state_n  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (advance) begin
                    wat_n = wat + FILL_STEP;
                    if (wat + FILL_STEP >= level_q) state_n = ST_WASH;
                end
            end
            ST_WASH: begin
                if (advance) begin
                    wash_n = wash_cnt - 6'd1;
                    if (wash_cnt <= 6'd1) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (advance) begin
                    wat_n = (wat > DRAIN_STEP) ? wat - DRAIN_STEP : 6'd0;
                    if (wat <= DRAIN_STEP) state_n = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (advance) begin
                    spin_n = spin_cnt - 6'd1;
                    if (spin_cnt <= 6'd1) state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                wat_n = 6'd0;
                if (uStart) state_n = ST_IDLE;
            end
`ifdef LAMP_TEST_EN
            ST_LAMP: begin
                if (uTick) begin
                    if (lamp_cnt <= 2'd1) state_n = ST_IDLE;
                    else                  lamp_n  = lamp_cnt - 2'd1;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        tot_n   = wash_n + spin_n;
        cur_n   = 6'd0;
        wat_o_n = wat_n;
        done_n  = 1'b0;
        unique case (state_n)
            ST_IDLE:  tot_n = prog_total(prog_sel);
            ST_FILL:  cur_n = GLYPH_BLANK;
            ST_WASH:  cur_n = wash_n;
            ST_DRAIN: cur_n = GLYPH_BLANK;
            ST_SPIN:  cur_n = spin_n;
            ST_DONE: begin
                tot_n   = GLYPH_END;
                cur_n   = GLYPH_END;
                wat_o_n = 6'd0;
                done_n  = 1'b1;
            end
`ifdef LAMP_TEST_EN
            ST_LAMP: begin
                tot_n   = GLYPH_LAMP;
                cur_n   = GLYPH_LAMP;
                wat_o_n = GLYPH_LAMP;
            end
`endif
            default: ;
        endcase
        if (blink_n) begin
            tot_n = GLYPH_BLANK;
            cur_n = GLYPH_BLANK;
        end
    end

    // State, counters and registered display outputs.
    always_ff @(posedge clk) begin
        if (!uRst_) begin
            level_q  <= 6'd0;
            wash_cnt <= 6'd0;
            spin_cnt <= 6'd0;
            wat      <= 6'd0;
            paused   <= 1'b0;
            blink    <= 1'b0;
            yDone    <= 1'b0;
`ifdef LAMP_TEST_EN
            state    <= ST_LAMP;
            lamp_cnt <= LAMP_TICKS;
            yTot     <= GLYPH_LAMP;
            yCur     <= GLYPH_LAMP;
            yWat     <= GLYPH_LAMP;
`else
            state    <= ST_IDLE;
            yTot     <= RESET_TOTAL;
            yCur     <= 6'd0;
            yWat     <= 6'd0;
`endif
        end else begin
            state    <= state_n;
            level_q  <= level_n;
            wash_cnt <= wash_n;
            spin_cnt <= spin_n;
            wat      <= wat_n;
            paused   <= paused_n;
            blink    <= blink_n;
            yTot     <= tot_n;
            yCur     <= cur_n;
            yWat     <= wat_o_n;
            yDone    <= done_n;
`ifdef LAMP_TEST_EN
            lamp_cnt <= lamp_n;
`endif
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: directed scenarios plus random
// stimulus against a behavioural model of the wash program rules.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       uRst_ = 1'b0;
    logic       uTick = 1'b0;
    logic       uStart = 1'b0;
    logic       uPause = 1'b0;
    logic [1:0] uMode = 2'd0;
    logic [5:0] yTot, yCur, yWat;
    logic [2:0] yPhase;
    logic       yDone;

    int checks = 0;
    int failures = 0;

`ifdef LAMP_TEST_EN
    localparam bit LAMP_EN = 1'b1;
`else
    localparam bit LAMP_EN = 1'b0;
`endif

    // phase numbers follow the state list order: idle fill wash drain spin done lamp
    localparam int P_IDLE = 0, P_FILL = 1, P_WASH = 2, P_DRAIN = 3, P_SPIN = 4, P_DONE = 5, P_LAMP = 6;

    int LVL[4] = '{20, 12, 30, 16};
    int WSH[4] = '{30, 12, 40, 8};
    int SPN[4] = '{10, 6, 12, 4};

    int m_ph, m_mode, m_umode, m_wat, m_wash, m_spin, m_lamp;
    bit m_paused, m_blink;

    wash_sequencer dut (
        .clk    (clk),
        .uRst_  (uRst_),
        .uTick  (uTick),
        .uStart (uStart),
        .uPause (uPause),
        .uMode  (uMode),
        .yTot   (yTot),
        .yCur   (yCur),
        .yWat   (yWat),
        .yPhase (yPhase),
        .yDone  (yDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_running();
        return (m_ph >= P_FILL) && (m_ph <= P_SPIN);
    endfunction

    // One clock of the wash rules.
    task automatic model_step(input bit tk, input bit st, input bit pz, input int md, input bit rs);
        bit adv;
        if (!rs) begin
            m_ph = LAMP_EN ? P_LAMP : P_IDLE;
            m_mode = 0; m_umode = 0; m_wat = 0; m_wash = 0; m_spin = 0;
            m_paused = 0; m_blink = 0; m_lamp = 3;
            return;
        end
        m_umode = md;
        adv = 0;
        if (is_running() && pz) begin
            m_paused = !m_paused;
            m_blink = 0;
            adv = tk && !m_paused;
        end else if (is_running() && tk) begin
            if (m_paused) m_blink = !m_blink;
            else adv = 1;
        end
        case (m_ph)
            P_IDLE: if (st) begin
                m_mode = md; m_wash = WSH[md]; m_spin = SPN[md];
                m_wat = 0; m_paused = 0; m_blink = 0; m_ph = P_FILL;
            end
            P_FILL: if (adv) begin
                m_wat += 2;
                if (m_wat >= LVL[m_mode]) m_ph = P_WASH;
            end
            P_WASH: if (adv) begin
                m_wash--;
                if (m_wash == 0) m_ph = P_DRAIN;
            end
            P_DRAIN: if (adv) begin
                m_wat = (m_wat > 4) ? m_wat - 4 : 0;
                if (m_wat == 0) m_ph = P_SPIN;
            end
            P_SPIN: if (adv) begin
                m_spin--;
                if (m_spin == 0) m_ph = P_DONE;
            end
            P_DONE: if (st) m_ph = P_IDLE;
            P_LAMP: if (tk) begin
                m_lamp--;
                if (m_lamp == 0) m_ph = P_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        int et, ec, ew;
        et = m_wash + m_spin; ec = 0; ew = m_wat;
        case (m_ph)
            P_IDLE:  et = WSH[m_umode] + SPN[m_umode];
            P_FILL, P_DRAIN: ec = 55;
            P_WASH:  ec = m_wash;
            P_SPIN:  ec = m_spin;
            P_DONE:  begin et = 60; ec = 60; ew = 0; end
            P_LAMP:  begin et = 56; ec = 56; ew = 56; end
            default: ;
        endcase
        if (is_running() && m_blink) begin et = 55; ec = 55; end
        chk("tot", int'(yTot), et);
        chk("cur", int'(yCur), ec);
        chk("wat", int'(yWat), ew);
        chk("phase", int'(yPhase), m_ph);
        chk("done", int'(yDone), int'(m_ph == P_DONE));
    endtask

    task automatic step(input bit tk, input bit st, input bit pz);
        uTick = tk; uStart = st; uPause = pz;
        @(posedge clk);
        model_step(tk, st, pz, int'(uMode), uRst_);
        #1;
        compare_all();
        uTick = 0; uStart = 0; uPause = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic do_reset();
        uRst_ = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        uRst_ = 1;
`ifdef LAMP_TEST_EN
        chk("lamp_tot", int'(yTot), 56);
        chk("lamp_wat", int'(yWat), 56);
        step(0, 1, 0);
        chk("lamp_start_ignored", int'(yPhase), P_LAMP);
        ticks(2);
        chk("lamp_cur_2ticks", int'(yCur), 56);
        ticks(1);
        chk("lamp_exit", int'(yPhase), P_IDLE);
`else
        chk("rst_tot", int'(yTot), 40);
        chk("rst_phase", int'(yPhase), P_IDLE);
`endif
    endtask

    initial begin
        uMode = 2'd0;
        do_reset();

        // mode 1 fill then full run
        uMode = 2'd1;
        step(0, 0, 0);
        chk("idle_tot_m1", int'(yTot), 18);
        step(0, 1, 0);
        chk("fill_phase", int'(yPhase), P_FILL);
        for (int i = 1; i <= 6; i++) begin
            ticks(1);
            chk("fill_wat", int'(yWat), 2 * i);
        end
        chk("wash_phase", int'(yPhase), P_WASH);
        chk("wash_cur", int'(yCur), 12);
        chk("wash_tot", int'(yTot), 18);
        ticks(12);
        chk("drain_phase", int'(yPhase), P_DRAIN);
        ticks(1); chk("drain_8", int'(yWat), 8);
        ticks(1); chk("drain_4", int'(yWat), 4);
        ticks(1); chk("drain_0", int'(yWat), 0);
        chk("spin_phase", int'(yPhase), P_SPIN);
        step(0, 1, 0);
        chk("start_ignored", int'(yPhase), P_SPIN);
        ticks(6);
        chk("done_tot", int'(yTot), 60);
        chk("done_cur", int'(yCur), 60);
        chk("done_flag", int'(yDone), 1);
        step(0, 0, 1);
        chk("done_pause_ignored", int'(yPhase), P_DONE);
        step(0, 1, 0);
        chk("ack_idle", int'(yPhase), P_IDLE);

        // mode 3: tick and pause together in SPIN
        uMode = 2'd3;
        step(0, 1, 1);
        chk("start_beats_pause", int'(yPhase), P_FILL);
        ticks(8 + 8 + 4);
        chk("m3_spin", int'(yPhase), P_SPIN);
        ticks(1);
        chk("m3_spin3", int'(yCur), 3);
        step(1, 0, 1);
        chk("tick_pause_cur", int'(yCur), 3);
        chk("tick_pause_phase", int'(yPhase), P_SPIN);
        step(0, 0, 1);
        ticks(3);
        chk("m3_done", int'(yDone), 1);
        step(0, 1, 0);

        // mode 0: pause blinking in WASH, then reset mid-drain
        uMode = 2'd0;
        step(0, 1, 0);
        ticks(10 + 5);
        chk("m0_cur25", int'(yCur), 25);
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            chk("blink_cur", int'(yCur), (i % 2 == 0) ? 55 : 25);
        end
        step(0, 0, 1);
        chk("unpause_cur", int'(yCur), 25);
        ticks(1);
        chk("resume_cur", int'(yCur), 24);
        ticks(24);
        chk("m0_drain", int'(yPhase), P_DRAIN);
        ticks(1);
        chk("m0_drain16", int'(yWat), 16);
        uRst_ = 0;
        step(0, 0, 0);
        uRst_ = 1;
        chk("rst_mid_done", int'(yDone), 0);
`ifdef LAMP_TEST_EN
        chk("rst_mid_phase", int'(yPhase), P_LAMP);
`else
        chk("rst_mid_phase", int'(yPhase), P_IDLE);
        chk("rst_mid_wat", int'(yWat), 0);
        chk("rst_mid_tot", int'(yTot), 40);
`endif

        // random traffic against the model
        for (int n = 0; n < 6000; n++) begin
            bit tk, st, pz;
            if ($urandom_range(0, 39) == 0) uMode = 2'($urandom_range(0, 3));
            uRst_ = ($urandom_range(0, 999) != 0);
            tk = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 24) == 0);
            pz = ($urandom_range(0, 19) == 0);
            step(tk, st, pz);
        end
        uRst_ = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 The clock port SHALL be clk (input, 1 bit); all state changes on its rising edge.
REQ-002 The reset port SHALL be uRst_ (input, 1 bit); reset is synchronous and active-low.
REQ-003 uTick (input, 1 bit) SHALL be a one-clk-wide 1 Hz strobe; all timing advances only on it.
REQ-004 uStart (input, 1 bit) SHALL be a one-clk pulse that starts a program or acknowledges completion.
REQ-005 uPause (input, 1 bit) SHALL be a one-clk pulse that toggles pause while running.
REQ-006 uMode (input, 2 bits) SHALL select the program; it is sampled only in IDLE.
REQ-007 yTot, yCur and yWat (outputs, 6 bits each) SHALL drive the time/time/water display fields; values 0-54 are numbers and 55-61 are reserved glyph codes.
REQ-008 yPhase (output, 3 bits) SHALL be the encoded FSM state; yDone (output, 1 bit) SHALL be high only in DONE.

Function
REQ-009 The FSM states SHALL be IDLE, FILL, WASH, DRAIN, SPIN and DONE, with an orthogonal paused flag.
REQ-010 Program table (level/wash/spin) SHALL be: mode0 20/30/10, mode1 12/12/6, mode2 30/40/12, mode3 16/8/4.
REQ-011 IDLE + uStart SHALL latch uMode, load the wash and spin counters, clear paused and enter FILL on the next clk.
REQ-012 FILL: each unpaused uTick SHALL add 2 to yWat; on the tick where yWat reaches the level, the next state SHALL be WASH.
REQ-013 WASH/SPIN: each unpaused uTick SHALL decrement the phase counter; on the tick it reaches 0, WASH SHALL go to DRAIN and SPIN SHALL go to DONE.
REQ-014 DRAIN: each unpaused uTick SHALL subtract 4 from yWat, saturating at 0; on the tick it reaches 0, the next state SHALL be SPIN.
REQ-015 yTot SHALL equal the remaining wash count plus the remaining spin count in every state except DONE; in IDLE it SHALL show the selected uMode total.
REQ-016 yCur SHALL show the active counter in WASH/SPIN, 55 (blank) in FILL/DRAIN, and 0 in IDLE.
REQ-017 DONE SHALL drive yTot=60, yCur=60, yWat=0 and yDone=1; uStart in DONE SHALL return to IDLE.
REQ-018 uPause SHALL toggle paused only in FILL/WASH/DRAIN/SPIN; it SHALL be ignored in IDLE/DONE.
REQ-019 While paused, uTick SHALL not advance counters but SHALL toggle a blink bit; when the bit is 1, yCur and yTot SHALL read 55.
REQ-020 Leaving pause SHALL clear the blink bit.
REQ-021 If uTick and uPause coincide, pause SHALL apply first and the tick SHALL be discarded when entering pause.
REQ-022 If uStart and uPause coincide in IDLE, start SHALL win.
REQ-023 uStart outside IDLE/DONE SHALL be ignored.
REQ-024 Outputs SHALL be registered, changing one clk after the causing event.

Reset
REQ-025 uRst_=0 at a clk edge SHALL force IDLE, paused=0, blink=0, yWat=0, yCur=0, yDone=0, yPhase=IDLE, and yTot=the total for the mode latched as 0 (40), at any time including mid-program.

Configuration
REQ-026 With LAMP_TEST_EN defined, reset SHALL enter a LAMP state that drives yTot=yCur=yWat=56 for 3 uTicks, then IDLE; uStart SHALL be ignored during LAMP.
REQ-027 Without LAMP_TEST_EN, reset SHALL go directly to IDLE and the LAMP state SHALL not exist.

Structure
REQ-028 Package wash_pkg SHALL hold the state enum, the glyph constants (GLYPH_BLANK=55, GLYPH_LAMP=56, GLYPH_END=60), the fill step 2, the drain step 4, and the program table type.
REQ-029 The sub-module wash_program_table SHALL map uMode to level/wash/spin combinationally.

Verification
REQ-030 Reset, uMode=1, uStart, 6 ticks -> yWat 2,4,...,12 and WASH with yCur=12, yTot=18.
REQ-031 Mode 1 run to end -> 12 WASH ticks, 3 DRAIN ticks (12->8->4->0), 6 SPIN ticks, then DONE with yTot=yCur=60, yDone=1; uStart -> IDLE.
REQ-032 Mode 0, pause in WASH at yCur=25, 4 ticks -> yCur alternates 55/25, counters frozen; unpause -> yCur=25, next tick 24.
REQ-033 uTick and uPause in the same clk in SPIN -> paused, counter unchanged.
REQ-034 Reset asserted mid-DRAIN -> next clk IDLE, yWat=0, yDone=0.
REQ-035 With LAMP_TEST_EN: after reset, all fields read 56 for 3 ticks, uStart is ignored, then IDLE.
